// File: rtl/eth_rx_frame_filter_if.sv
// -----------------------------------------------------------------------------
// eth_rx_frame_filter_if
// Byte-wide AXI-stream bundle without backpressure, used on both sides of the
// receive frame filter.
//   tdata  : stream byte
//   tvalid : byte valid (gaps allowed)
//   tlast  : last byte of frame
//   tuser  : frame error flag
// Modports:
//   master : drives the stream
//   slave  : consumes the stream
// Handshake: there is no tready. A beat transfers on every clock edge where
// tvalid is high, and the consumer must accept it.
// -----------------------------------------------------------------------------
interface eth_rx_frame_filter_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tlast;
   logic                  tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser);
   modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser);
endinterface

// File: rtl/eth_rx_frame_filter.sv
// -----------------------------------------------------------------------------
// eth_rx_frame_filter
// Receive-side frame filter placed between the GMII/MII frame receiver and the
// RX FIFO. It does the following:
//   - filters frames by destination MAC (unicast, broadcast, multicast, promisc)
//   - flags frames shorter than MIN_LEN as runt
//   - truncates frames longer than MAX_LEN and flags them as oversize
//   - merges all error causes into m_axis.tuser on the last beat
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   s_axis (slave)      : input stream (no backpressure, FCS already stripped)
//   m_axis (master)     : output stream, 6 valid beats behind the input
//   cfg_mac_addr        : local MAC; [47:40] is the first DA byte on the wire
//   cfg_promisc         : accept every destination
//   cfg_broadcast_en    : accept the broadcast address
//   cfg_multicast_en    : accept group addresses other than broadcast
//   stat_frame_good     : pulse, forwarded frame with tuser = 0
//   stat_frame_bad      : pulse, forwarded frame with tuser = 1, or runt drop
//   stat_frame_filtered : pulse, frame dropped by the DA filter
//   stat_runt           : pulse, frame length < MIN_LEN
//   stat_oversize       : pulse, frame length > MAX_LEN
//   state_dbg           : current FSM state
// Handshake: there is no ready on either side. A beat moves on every edge where
// tvalid is high.
// -----------------------------------------------------------------------------
module eth_rx_frame_filter #(
   parameter int DATA_WIDTH  = 8,
   parameter int MIN_LEN     = 60,
   parameter int MAX_LEN     = 1518,
   parameter int IDLE_RESYNC = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   eth_rx_frame_filter_if.slave         s_axis,
   eth_rx_frame_filter_if.master        m_axis,
   input  logic [47:0]                  cfg_mac_addr,
   input  logic                         cfg_promisc,
   input  logic                         cfg_broadcast_en,
   input  logic                         cfg_multicast_en,
   output logic                         stat_frame_good,
   output logic                         stat_frame_bad,
   output logic                         stat_frame_filtered,
   output logic                         stat_runt,
   output logic                         stat_oversize,
   output logic [2:0]                   state_dbg
);

   generate
      if (DATA_WIDTH != 8) begin : g_bad_width
         $fatal(1, "eth_rx_frame_filter: DATA_WIDTH must be 8");
      end
   endgenerate

   localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
   localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
   localparam logic [5:0]  RESYNC_LAST = 6'(IDLE_RESYNC - 1);

   typedef enum logic [2:0] {
      S_RESYNC  = 3'd0,
      S_IDLE    = 3'd1,
      S_HEAD    = 3'd2,
      S_PASS    = 3'd3,
      S_DRAIN   = 3'd4,
      S_DISCARD = 3'd5
   } state_t;

   state_t      state;
   logic [47:0] sh;            // six-byte delay line; [47:40] is the oldest byte
   logic [10:0] count;         // bytes of the current frame, saturating
   logic [5:0]  idle_cnt;
   logic [2:0]  drain_cnt;
   logic        err_acc;
   logic        oversize;
   logic        tail_pending;  // truncated frame still has input bytes to drop
   logic        filt;          // DISCARD is dropping a filtered frame
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic        out_user;

   logic [47:0] da;
   logic        is_bcast;
   logic        is_mcast;
   logic        accept;
   logic        runt_now;
   logic [10:0] count_inc;

   // The decision beat supplies the sixth DA byte on the input itself.
   assign da        = {sh[39:0], s_axis.tdata};
   assign is_bcast  = (da == 48'hFFFF_FFFF_FFFF);
   assign is_mcast  = da[40] & ~is_bcast;
   assign accept    = cfg_promisc | (da == cfg_mac_addr) |
                      (is_bcast & cfg_broadcast_en) | (is_mcast & cfg_multicast_en);
   assign runt_now  = (count < MIN_L);
   assign count_inc = (count == 11'h7FF) ? count : count + 11'd1;

   assign m_axis.tdata  = out_data;
   assign m_axis.tvalid = out_valid;
   assign m_axis.tlast  = out_last;
   assign m_axis.tuser  = out_user;
   assign state_dbg     = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state               <= S_RESYNC;
         sh                  <= '0;
         count               <= '0;
         idle_cnt            <= '0;
         drain_cnt           <= '0;
         err_acc             <= 1'b0;
         oversize            <= 1'b0;
         tail_pending        <= 1'b0;
         filt                <= 1'b0;
         out_data            <= '0;
         out_valid           <= 1'b0;
         out_last            <= 1'b0;
         out_user            <= 1'b0;
         stat_frame_good     <= 1'b0;
         stat_frame_bad      <= 1'b0;
         stat_frame_filtered <= 1'b0;
         stat_runt           <= 1'b0;
         stat_oversize       <= 1'b0;
      end else begin
         out_valid           <= 1'b0;
         out_last            <= 1'b0;
         out_user            <= 1'b0;
         stat_frame_good     <= 1'b0;
         stat_frame_bad      <= 1'b0;
         stat_frame_filtered <= 1'b0;
         stat_runt           <= 1'b0;
         stat_oversize       <= 1'b0;

         case (state)
            // After reset the input may be mid-frame. Wait for a frame end or a
            // long enough idle gap before trusting the next beat as a frame start.
            S_RESYNC: begin
               if (s_axis.tvalid) begin
                  idle_cnt <= '0;
                  if (s_axis.tlast) state <= S_IDLE;
               end else if (idle_cnt == RESYNC_LAST) begin
                  idle_cnt <= '0;
                  state    <= S_IDLE;
               end else begin
                  idle_cnt <= idle_cnt + 6'd1;
               end
            end

            S_IDLE: begin
               if (s_axis.tvalid) begin
                  sh           <= {sh[39:0], s_axis.tdata};
                  count        <= 11'd1;
                  err_acc      <= s_axis.tuser;
                  oversize     <= 1'b0;
                  tail_pending <= 1'b0;
                  filt         <= 1'b0;
                  if (s_axis.tlast) begin
                     stat_frame_bad <= 1'b1;
                     stat_runt      <= 1'b1;
                  end else begin
                     state <= S_HEAD;
                  end
               end
            end

            S_HEAD: begin
               if (s_axis.tvalid) begin
                  sh      <= da;
                  count   <= count_inc;
                  err_acc <= err_acc | s_axis.tuser;
                  drain_cnt <= '0;
                  if (count == 11'd5) begin
                     if (accept) begin
                        state <= s_axis.tlast ? S_DRAIN : S_PASS;
                     end else if (s_axis.tlast) begin
                        stat_frame_filtered <= 1'b1;
                        state               <= S_IDLE;
                     end else begin
                        filt  <= 1'b1;
                        state <= S_DISCARD;
                     end
                  end else if (s_axis.tlast) begin
                     stat_frame_bad <= 1'b1;
                     stat_runt      <= 1'b1;
                     state          <= S_IDLE;
                  end
               end
            end

            S_PASS: begin
               if (s_axis.tvalid) begin
                  count     <= count_inc;
                  drain_cnt <= '0;
                  if (count == MAX_L) begin
                     // Byte MAX_LEN+1 is dropped; the buffer still holds the
                     // last six bytes that fit.
                     oversize     <= 1'b1;
                     tail_pending <= ~s_axis.tlast;
                     state        <= S_DRAIN;
                  end else begin
                     out_data  <= sh[47:40];
                     out_valid <= 1'b1;
                     sh        <= da;
                     err_acc   <= err_acc | s_axis.tuser;
                     if (s_axis.tlast) state <= S_DRAIN;
                  end
               end
            end

            S_DRAIN: begin
               out_data  <= sh[47:40];
               out_valid <= 1'b1;
               sh        <= {sh[39:0], 8'h00};
               drain_cnt <= drain_cnt + 3'd1;
               if (s_axis.tvalid && s_axis.tlast) tail_pending <= 1'b0;
               if (drain_cnt == 3'd5) begin
                  out_last        <= 1'b1;
                  out_user        <= err_acc | runt_now | oversize;
                  stat_frame_good <= ~(err_acc | runt_now | oversize);
                  stat_frame_bad  <= err_acc | runt_now | oversize;
                  stat_runt       <= runt_now;
                  stat_oversize   <= oversize;
                  if (tail_pending && !(s_axis.tvalid && s_axis.tlast))
                     state <= S_DISCARD;
                  else
                     state <= S_IDLE;
               end
            end

            S_DISCARD: begin
               if (s_axis.tvalid && s_axis.tlast) begin
                  stat_frame_filtered <= filt;
                  state               <= S_IDLE;
               end
            end

            default: state <= S_RESYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// -----------------------------------------------------------------------------
// tb_eth_rx_frame_filter
// Directed bench for eth_rx_frame_filter. Frames are driven byte by byte, and
// the expected output beats are queued as {tlast, tuser, tdata}. Status pulses
// are counted and compared per frame against hand-derived values.
// -----------------------------------------------------------------------------
module tb_eth_rx_frame_filter;

   // clock / reset
   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   eth_rx_frame_filter_if s_if ();
   eth_rx_frame_filter_if m_if ();

   logic [47:0] cfg_mac_addr;
   logic        cfg_promisc;
   logic        cfg_broadcast_en;
   logic        cfg_multicast_en;
   logic        stat_frame_good;
   logic        stat_frame_bad;
   logic        stat_frame_filtered;
   logic        stat_runt;
   logic        stat_oversize;
   logic [2:0]  state_dbg;

   eth_rx_frame_filter dut (
      .clk                 (clk),
      .rst                 (rst),
      .s_axis              (s_if),
      .m_axis              (m_if),
      .cfg_mac_addr        (cfg_mac_addr),
      .cfg_promisc         (cfg_promisc),
      .cfg_broadcast_en    (cfg_broadcast_en),
      .cfg_multicast_en    (cfg_multicast_en),
      .stat_frame_good     (stat_frame_good),
      .stat_frame_bad      (stat_frame_bad),
      .stat_frame_filtered (stat_frame_filtered),
      .stat_runt           (stat_runt),
      .stat_oversize       (stat_oversize),
      .state_dbg           (state_dbg)
   );

   localparam logic [47:0] MAC_LOCAL = 48'h02_00_00_00_00_01;
   localparam logic [47:0] MAC_OTHER = 48'h02_00_00_00_00_02;
   localparam logic [47:0] MAC_BCAST = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [47:0] MAC_MCAST = 48'h01_00_5E_00_00_01;

   // scoreboard
   logic [9:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int cnt_good = 0, cnt_bad = 0, cnt_filt = 0, cnt_runt = 0, cnt_over = 0;
   bit sb_off = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] frame_byte(input logic [47:0] da, input int i);
      if (i < 6) return da[47-8*i -: 8];
      return 8'(i * 7 + 3);
   endfunction

   // output monitor, sampled on the falling edge
   always @(negedge clk) begin
      cnt_good = cnt_good + int'(stat_frame_good);
      cnt_bad  = cnt_bad  + int'(stat_frame_bad);
      cnt_filt = cnt_filt + int'(stat_frame_filtered);
      cnt_runt = cnt_runt + int'(stat_runt);
      cnt_over = cnt_over + int'(stat_oversize);
      if (m_if.tvalid && !sb_off) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL extra_beat observed=%0h expected=none",
                   {m_if.tlast, m_if.tuser, m_if.tdata});
         end else begin
            check("out_beat", {22'd0, m_if.tlast, m_if.tuser, m_if.tdata}, {22'd0, exp_q.pop_front()});
         end
      end
   end

   // driver tasks
   task automatic idle_inputs();
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
      s_if.tdata  = 8'h00;
   endtask

   task automatic send_frame(input logic [47:0] da, input int len, input int err_beat, input bit paced);
      for (int i = 0; i < len; i++) begin
         @(posedge clk); #1;
         s_if.tvalid = 1'b1;
         s_if.tdata  = frame_byte(da, i);
         s_if.tlast  = (i == len - 1);
         s_if.tuser  = (i == err_beat);
         if (paced) begin
            @(posedge clk); #1;
            idle_inputs();
         end
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic expect_frame(input logic [47:0] da, input int out_len, input bit user);
      for (int i = 0; i < out_len; i++)
         exp_q.push_back({(i == out_len - 1), user & (i == out_len - 1), frame_byte(da, i)});
   endtask

   task automatic end_frame(input string tag, input int good, input int bad, input int filt,
                            input int runt, input int over);
      repeat (20) @(posedge clk);
      #1;
      check({tag, "_good"}, cnt_good, good);
      check({tag, "_bad"},  cnt_bad,  bad);
      check({tag, "_filt"}, cnt_filt, filt);
      check({tag, "_runt"}, cnt_runt, runt);
      check({tag, "_over"}, cnt_over, over);
      check({tag, "_qlen"}, exp_q.size(), 0);
      cnt_good = 0; cnt_bad = 0; cnt_filt = 0; cnt_runt = 0; cnt_over = 0;
   endtask

   // watchdog
   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // directed sequence
   initial begin
      rst              = 1'b1;
      cfg_mac_addr     = MAC_LOCAL;
      cfg_promisc      = 1'b0;
      cfg_broadcast_en = 1'b0;
      cfg_multicast_en = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", m_if.tvalid, 0);
      check("rst_tlast",  m_if.tlast,  0);
      check("rst_tuser",  m_if.tuser,  0);
      check("rst_stats",  {stat_frame_good, stat_frame_bad, stat_frame_filtered, stat_runt, stat_oversize}, 0);
      check("rst_state",  state_dbg, 0);
      rst = 1'b0;

      // idle long enough to leave resync without any tlast
      repeat (40) @(posedge clk);
      #1;
      check("resync_exit_state", state_dbg, 1);

      expect_frame(MAC_LOCAL, 64, 1'b0);
      send_frame(MAC_LOCAL, 64, -1, 1'b0);
      end_frame("uc64", 1, 0, 0, 0, 0);

      send_frame(MAC_OTHER, 64, -1, 1'b0);
      end_frame("other64", 0, 0, 1, 0, 0);

      cfg_promisc = 1'b1;
      expect_frame(MAC_OTHER, 64, 1'b0);
      send_frame(MAC_OTHER, 64, -1, 1'b0);
      end_frame("promisc64", 1, 0, 0, 0, 0);
      cfg_promisc = 1'b0;

      send_frame(MAC_BCAST, 60, -1, 1'b0);
      end_frame("bc60_off", 0, 0, 1, 0, 0);

      cfg_broadcast_en = 1'b1;
      expect_frame(MAC_BCAST, 60, 1'b0);
      send_frame(MAC_BCAST, 60, -1, 1'b0);
      end_frame("bc60_on", 1, 0, 0, 0, 0);

      expect_frame(MAC_BCAST, 59, 1'b1);
      send_frame(MAC_BCAST, 59, -1, 1'b0);
      end_frame("bc59", 0, 1, 0, 1, 0);

      send_frame(MAC_LOCAL, 4, -1, 1'b0);
      end_frame("short4", 0, 1, 0, 1, 0);

      send_frame(MAC_MCAST, 64, -1, 1'b0);
      end_frame("mc_off", 0, 0, 1, 0, 0);

      cfg_multicast_en = 1'b1;
      expect_frame(MAC_MCAST, 64, 1'b0);
      send_frame(MAC_MCAST, 64, -1, 1'b0);
      end_frame("mc_on", 1, 0, 0, 0, 0);
      cfg_multicast_en = 1'b0;

      expect_frame(MAC_LOCAL, 1518, 1'b1);
      send_frame(MAC_LOCAL, 1520, -1, 1'b0);
      end_frame("over1520", 0, 1, 0, 0, 1);

      expect_frame(MAC_LOCAL, 64, 1'b0);
      send_frame(MAC_LOCAL, 64, -1, 1'b0);
      end_frame("after_over", 1, 0, 0, 0, 0);

      expect_frame(MAC_LOCAL, 1518, 1'b0);
      send_frame(MAC_LOCAL, 1518, -1, 1'b0);
      end_frame("max1518", 1, 0, 0, 0, 0);

      expect_frame(MAC_LOCAL, 1518, 1'b1);
      send_frame(MAC_LOCAL, 1519, -1, 1'b0);
      end_frame("over1519", 0, 1, 0, 0, 1);

      // long tail continues past the drain and must not count as filtered
      expect_frame(MAC_LOCAL, 1518, 1'b1);
      send_frame(MAC_LOCAL, 1530, -1, 1'b0);
      end_frame("over1530", 0, 1, 0, 0, 1);

      expect_frame(MAC_LOCAL, 100, 1'b1);
      send_frame(MAC_LOCAL, 100, 39, 1'b1);
      end_frame("paced_err", 0, 1, 0, 0, 0);

      // reset in the middle of an accepted frame
      sb_off = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         s_if.tvalid = 1'b1;
         s_if.tdata  = frame_byte(MAC_LOCAL, i);
         s_if.tlast  = (i == 199);
         s_if.tuser  = 1'b0;
         if (i == 29) begin
            rst = 1'b1;
            #1;
            check("midrst_tvalid", m_if.tvalid, 0);
            check("midrst_stats", {stat_frame_good, stat_frame_bad, stat_frame_filtered, stat_runt, stat_oversize}, 0);
            check("midrst_state", state_dbg, 0);
            sb_off = 1'b0;
         end
         if (i == 34) rst = 1'b0;
      end
      @(posedge clk); #1;
      idle_inputs();
      end_frame("midrst", 0, 0, 0, 0, 0);

      expect_frame(MAC_LOCAL, 64, 1'b0);
      send_frame(MAC_LOCAL, 64, -1, 1'b0);
      end_frame("post_rst", 1, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
